// File: rtl/cos_horner_ctrl.sv
// cos_horner_ctrl: Horner-rule sequencer for an even cosine polynomial in signed Q(WI).(WF),
// time-sharing one saturating fixed-point multiplier between the squaring and every MAC step.
module cos_horner_ctrl #(
    parameter int WI    = 4,
    parameter int WF    = 16,
    parameter int NCOEF = 4,
    localparam int W    = WI + WF,
    localparam int KW   = $clog2(NCOEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       x_in,
    input  logic [NCOEF*W-1:0] coef_flat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       y_out,
    output logic               busy,
    output logic               sat_flag
);
    typedef enum logic [1:0] {IDLE, SQUARE, HORNER, DONE} state_t;

    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    state_t             state_q;
    logic [W-1:0]       x_q, x2_q, acc_q, y_q;
    logic [NCOEF*W-1:0] coef_q;
    logic [KW-1:0]      k_q;
    logic               out_valid_q, in_ready_q, busy_q, sat_q;

    logic [W-1:0]       mul_a, mul_b, mul_d, c_k, sum_d;
    logic [2*W-1:0]     prod;
    logic signed [2*W-1:0] prod_sh;
    logic [W:0]         sum_w;
    logic               mul_ovf, add_ovf;

    // Single multiplier: operands are steered by state, squaring x in SQUARE and acc*x2 in HORNER.
    always_comb begin
        mul_a   = (state_q == SQUARE) ? x_q : acc_q;
        mul_b   = (state_q == SQUARE) ? x_q : x2_q;
        prod    = {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};
        prod_sh = $signed(prod) >>> WF;
        mul_ovf = prod_sh[2*W-1:W-1] != {(W+1){prod_sh[W-1]}};
        mul_d   = mul_ovf ? (prod_sh[2*W-1] ? SMIN : SMAX) : prod_sh[W-1:0];
        c_k     = coef_q[k_q*W +: W];
        sum_w   = {mul_d[W-1], mul_d} + {c_k[W-1], c_k};
        add_ovf = sum_w[W] ^ sum_w[W-1];
        sum_d   = add_ovf ? (sum_w[W] ? SMIN : SMAX) : sum_w[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            x2_q        <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            coef_q      <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid && in_ready_q) begin
                    x_q        <= x_in;
                    coef_q     <= coef_flat;
                    sat_q      <= 1'b0;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    state_q    <= SQUARE;
                end
                SQUARE: begin
                    x2_q    <= mul_d;
                    acc_q   <= coef_q[(NCOEF-1)*W +: W];
                    k_q     <= KW'(NCOEF-2);
                    sat_q   <= sat_q | mul_ovf;
                    state_q <= HORNER;
                end
                HORNER: begin
                    acc_q <= sum_d;
                    sat_q <= sat_q | mul_ovf | add_ovf;
                    if (k_q == '0) begin
                        y_q         <= sum_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        k_q <= k_q - 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y_out     = y_q;
    assign busy      = busy_q;
    assign sat_flag  = sat_q;
endmodule

// File: tb/tb_cos_horner_ctrl.sv
// tb_cos_horner_ctrl: scoreboard bench for cos_horner_ctrl with a plain-arithmetic polynomial model.
module tb_cos_horner_ctrl;
    localparam int W = 20;
    localparam int N = 4;
    localparam logic [N*W-1:0] COS    = {20'hFFFA5, 20'h00AAB, 20'hF8000, 20'h10000};
    localparam logic [N*W-1:0] ALLMAX = {N{20'h7FFFF}};

    logic clk = 0, rst = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, busy, sat_flag;
    logic [W-1:0] x_in = '0, y_out;
    logic [N*W-1:0] coef_flat = '0;

    int tests = 0, fails = 0, cyc = 0;
    bit rnd_ready = 0, prev_valid = 0, m_sat;

    typedef struct {logic [W-1:0] y; bit s; int acc;} exp_t;
    exp_t sb[$];
    exp_t mon_e;

    cos_horner_ctrl #(.WI(4), .WF(16), .NCOEF(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .coef_flat(coef_flat), .out_valid(out_valid), .out_ready(out_ready),
        .y_out(y_out), .busy(busy), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rnd_ready) out_ready = 1'($urandom_range(0, 1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint clamp(longint v);
        if (v > 524287) begin m_sat = 1; return 524287; end
        if (v < -524288) begin m_sat = 1; return -524288; end
        return v;
    endfunction

    function automatic longint qmul(longint a, longint b);
        return clamp((a * b) >>> 16);
    endfunction

    function automatic longint sx(logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    task automatic model(input logic [W-1:0] x, input logic [N*W-1:0] c,
                         output logic [W-1:0] y, output bit s);
        longint x2, acc;
        m_sat = 0;
        x2  = qmul(sx(x), sx(x));
        acc = sx(c[(N-1)*W +: W]);
        for (int k = N - 2; k >= 0; k--) acc = clamp(qmul(acc, x2) + sx(c[k*W +: W]));
        y = acc[W-1:0];
        s = m_sat;
    endtask

    function automatic logic [N*W-1:0] rand_coef();
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = 20'($urandom);
        return r;
    endfunction

    // Monitor: compares each new result against the oldest expectation, including latency.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && !prev_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got y=%h expected no result", y_out);
            end else begin
                mon_e = sb.pop_front();
                check("result_y", 32'(y_out), 32'(mon_e.y));
                check("result_sat", 32'(sat_flag), 32'(mon_e.s));
                check("latency", 32'(cyc - mon_e.acc), 32'(N));
            end
        end
        prev_valid = (out_valid === 1'b1) && !rst;
    end

    task automatic send(input logic [W-1:0] x, input logic [N*W-1:0] c,
                        input logic [W-1:0] ey, input bit es);
        int n = 0;
        @(negedge clk);
        in_valid = 1; x_in = x; coef_flat = c;
        while (in_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        if (in_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready=%b expected 1", in_ready);
            in_valid = 0;
        end else begin
            sb.push_back('{ey, es, cyc + 1});
            @(posedge clk);
            #1 in_valid = 0; x_in = 20'($urandom); coef_flat = rand_coef();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(in_ready === 1'b1 && out_valid === 1'b0) && n < 300) begin @(negedge clk); n++; end
        if (!(in_ready === 1'b1 && out_valid === 1'b0)) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] x, ey;
        logic [N*W-1:0] c;
        bit es;
        int n;
        #3 rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_y", 32'(y_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sat", 32'(sat_flag), 0);

        out_ready = 1;
        send('0, COS, 20'h10000, 0); wait_idle();
        send(20'h10000, COS, 20'h08A50, 0); wait_idle();
        send(20'h7FFFF, ALLMAX, 20'h7FFFF, 1); wait_idle();
        send('0, COS, 20'h10000, 0); wait_idle();

        // Back-pressure with a competing request held on the inputs.
        out_ready = 0;
        send(20'h10000, COS, 20'h08A50, 0);
        @(negedge clk);
        in_valid = 1; x_in = '0; coef_flat = COS;
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 5) begin x_in = 20'($urandom); coef_flat = rand_coef(); end
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_y", 32'(y_out), 32'h08A50);
            check("bp_in_ready", 32'(in_ready), 0);
        end
        x_in = '0; coef_flat = COS; out_ready = 1;
        @(negedge clk);
        check("release_out_valid", 32'(out_valid), 0);
        check("release_in_ready", 32'(in_ready), 1);
        sb.push_back('{20'h10000, 1'b0, cyc + 1});
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        check("reaccept_busy", 32'(busy), 1);
        check("reaccept_in_ready", 32'(in_ready), 0);
        wait_idle();

        // Asynchronous reset while in HORNER.
        send(20'h10000, COS, 20'h08A50, 0);
        @(posedge clk);
        #1 check("pre_rst_busy", 32'(busy), 1);
        #2 rst = 1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_y", 32'(y_out), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_sat", 32'(sat_flag), 0);
        sb.delete();
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", 32'(out_valid), 0);
        end

        rnd_ready = 1;
        for (int t = 0; t < 40; t++) begin
            x = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'($urandom_range(0, 419430) - 209715);
            c = ($urandom_range(0, 2) == 0) ? rand_coef() : COS;
            model(x, c, ey, es);
            send(x, c, ey, es);
        end
        @(posedge clk);
        #1 rnd_ready = 0; out_ready = 1;
        wait_idle();
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cos_horner_ctrl.md
Name: cos_horner_ctrl

Overview:
- Sequencer that evaluates the even cosine polynomial cos(x) ≈ c0 + x²·(c1 + x²·(c2 + x²·c3)) by Horner's rule.
- It time-shares one signed fixed-point multiplier, held inside the block, across all steps: one squaring, then NCOEF-1 multiply-accumulate steps.
- It sits between the angle source and the result consumer, with valid/ready handshakes on both sides.
- Every datum is signed Q(WI).(WF).

Parameters:
- WI, 4, integer bits including sign.
- WF, 16, fraction bits. W = WI+WF = 20.
- NCOEF, 4, number of polynomial coefficients. Must be 2 or more.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  request carries a valid angle.
- in_ready  out  1  block can accept a request.
- x_in  in  W  signed angle x, Q(WI).(WF).
- coef_flat  in  NCOEF*W  coefficient c_k at bits [k*W +: W], signed Q(WI).(WF).
- out_valid  out  1  result y_out is valid.
- out_ready  in  1  consumer accepts the result.
- y_out  out  W  signed result, Q(WI).(WF).
- busy  out  1  high whenever the state is not IDLE.
- sat_flag  out  1  saturation occurred during the current or last evaluation.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset, including reset asserted mid-evaluation:
  - state returns to IDLE;
  - y_out=0, out_valid=0, sat_flag=0, busy=0, in_ready=1;
  - internal x2, acc, k and the latched coefficients clear to 0;
  - any evaluation in progress is discarded and no result is produced.
- States: IDLE, SQUARE, HORNER, DONE.
- Multiply rule:
  - p = a*b at full 2W-bit signed width;
  - r = p >>> WF, an arithmetic shift, i.e. truncation toward -infinity;
  - saturate r to W-bit signed range [-2^(W-1), 2^(W-1)-1].
- Add rule: sum computed at W+1 bits, then saturated to W bits.
- Any saturation event sets sat_flag.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch x_in and all of coef_flat; clear sat_flag; go to SQUARE.
  - y_out holds the previous result.
- SQUARE, one cycle:
  - x2 ← sat(x*x);
  - acc ← c[NCOEF-1];
  - k ← NCOEF-2;
  - go to HORNER.
- HORNER, NCOEF-1 cycles:
  - acc ← satadd(satmul(acc, x2), c[k]);
  - if k==0, load y_out with the new acc, set out_valid=1 and go to DONE; otherwise decrement k.
- DONE:
  - out_valid=1; y_out and sat_flag are stable.
  - When out_ready=1: out_valid←0, go to IDLE.
  - Back-pressure holds DONE indefinitely.
  - in_ready=0, so a new request cannot overlap a pending result.
- Latency: out_valid rises NCOEF clock edges after the accepting edge (4 for the defaults).
  - With out_ready held high, throughput is one result every NCOEF+2 cycles.
- in_ready is 0 in SQUARE, HORNER and DONE. A held in_valid is ignored until IDLE.
- Only one multiplier instance is used; the squaring and every Horner step share it through operand muxes selected by state.
- Input changes on x_in or coef_flat after acceptance have no effect on the evaluation in progress.
- out_valid deasserts exactly on the edge where out_ready=1 in DONE.
- in_ready rises on the next cycle, with no combinational ready-to-valid path.

Test Plan:
- Coefficients for the cosine tests: c0=0x10000 (1.0), c1=0xF8000 (-0.5), c2=0x00AAB (≈1/24), c3=0xFFFA5 (≈-1/720).
- Reset then idle: assert rst mid-cycle, release, with no request -> in_ready=1, out_valid=0, y_out=0x00000, busy=0, sat_flag=0.
- x=0 with the cosine coefficients, out_ready=1 -> out_valid exactly 4 cycles after acceptance, y_out=0x10000, sat_flag=0.
- x=0x10000 (1.0) with the same coefficients -> y_out=0x08A50 (≈0.5403), sat_flag=0.
- Saturation: all coefficients 0x7FFFF, x=0x7FFFF -> y_out=0x7FFFF, sat_flag=1. Then x=0 with the cosine coefficients -> y_out=0x10000, sat_flag=0 (cleared on accept).
- Back-pressure and overlap: keep out_ready=0 for 10 cycles with in_valid held high, then change x_in and coef_flat -> out_valid and y_out stay stable, in_ready=0, and the result reflects the originally latched inputs. After out_ready=1 for one cycle -> out_valid=0, then in_ready=1 and the next request is accepted.
- Reset mid-operation: assert rst during HORNER -> outputs return to reset values immediately with no clock edge needed, and no out_valid pulse appears afterwards.
